// File: rtl/c2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c2c_pkg
// Description : Shared types and constants for the chip-to-chip link
//               master/slave control blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package c2c_pkg;

    localparam int unsigned C2C_DATA_W          = 3;
    localparam int unsigned C2C_TIMER_W         = 32;
    localparam int unsigned C2C_TIMEOUT_DEFAULT = 200_000_000;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_ACK  = 2'b01,
        SEND_DATA = 2'b10
    } c2c_state_e;

    // True on the last permitted cycle of a waiting phase.
    function automatic logic c2c_timeout_hit(
        input logic [C2C_TIMER_W-1:0] timer,
        input int unsigned            limit
    );
        logic [C2C_TIMER_W-1:0] last;
        last = C2C_TIMER_W'(limit - 1);
        return (timer == last);
    endfunction

endpackage : c2c_pkg
`default_nettype wire

// File: rtl/master_control_if.sv
`default_nettype none
// ============================================================================
// Module      : master_control_if
// Description : Button/switch inputs and inter-board pins of the link master.
// Revision    : 1.0 - initial release
// ============================================================================
interface master_control_if;
    import c2c_pkg::*;

    logic                  send;
    logic [C2C_DATA_W-1:0] data_sw;
    logic                  ack;
    logic                  request;
    logic                  valid;
    logic [C2C_DATA_W-1:0] data_out;
    logic                  notice;
    logic                  err;

    modport master (
        input  send,
        input  data_sw,
        input  ack,
        output request,
        output valid,
        output data_out,
        output notice,
        output err
    );

    modport slave (
        output send,
        output data_sw,
        output ack,
        input  request,
        input  valid,
        input  data_out,
        input  notice,
        input  err
    );

endinterface : master_control_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer, synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/master_control.sv
`default_nettype none
// ============================================================================
// Module      : master_control
// Description : Four-phase request/ack/valid handshake master with per-phase
//               timeout and sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module master_control
    import c2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = C2C_TIMEOUT_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    master_control_if.master   bus
);

    logic                   ack_s;
    c2c_state_e             state_q;
    logic [C2C_TIMER_W-1:0] timer_q;
    logic                   request_q;
    logic                   valid_q;
    logic [C2C_DATA_W-1:0]  data_out_q;
    logic                   notice_q;
    logic                   err_q;
    logic                   timeout_w;

    // ack comes from the other board, so it is resynchronised first.
    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.ack),
        .q_o (ack_s)
    );

    assign timeout_w = c2c_timeout_hit(timer_q, TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            notice_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (bus.send) begin
                        data_out_q <= bus.data_sw;
                        err_q      <= 1'b0;
                        request_q  <= 1'b1;
                        notice_q   <= 1'b1;
                        state_q    <= WAIT_ACK;
                    end
                end

                // Handshake is tested before timeout so it wins a tie.
                WAIT_ACK: begin
                    if (ack_s) begin
                        request_q <= 1'b0;
                        valid_q   <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= SEND_DATA;
                    end else if (timeout_w) begin
                        request_q <= 1'b0;
                        valid_q   <= 1'b0;
                        notice_q  <= 1'b0;
                        err_q     <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                SEND_DATA: begin
                    if (!ack_s) begin
                        valid_q  <= 1'b0;
                        notice_q <= 1'b0;
                        timer_q  <= '0;
                        state_q  <= IDLE;
                    end else if (timeout_w) begin
                        request_q <= 1'b0;
                        valid_q   <= 1'b0;
                        notice_q  <= 1'b0;
                        err_q     <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                default: begin
                    request_q <= 1'b0;
                    valid_q   <= 1'b0;
                    notice_q  <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.request  = request_q;
    assign bus.valid    = valid_q;
    assign bus.data_out = data_out_q;
    assign bus.notice   = notice_q;
    assign bus.err      = err_q;

endmodule : master_control
`default_nettype wire

// File: tb/tb_master_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_master_control
// Description : Directed self-checking bench for master_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_master_control;

    localparam int unsigned TMO = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    master_control_if u_if ();

    master_control #(
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic vld,
                           input logic [2:0] dat, input logic ntc, input logic er);
        chk({tag, ".request"},  32'(u_if.request),  32'(req));
        chk({tag, ".valid"},    32'(u_if.valid),    32'(vld));
        chk({tag, ".data_out"}, 32'(u_if.data_out), 32'(dat));
        chk({tag, ".notice"},   32'(u_if.notice),   32'(ntc));
        chk({tag, ".err"},      32'(u_if.err),      32'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        u_if.send    = 1'b0;
        u_if.data_sw = 3'b000;
        u_if.ack     = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk_all("reset", 0, 0, 3'b000, 0, 0);

        // ack toggling while idle has no effect
        u_if.ack = 1'b1;
        tick(4);
        chk_all("idle_ack_hi", 0, 0, 3'b000, 0, 0);
        u_if.ack = 1'b0;
        tick(4);
        chk_all("idle_ack_lo", 0, 0, 3'b000, 0, 0);

        // nominal transfer of 3'b101
        u_if.data_sw = 3'b101;
        u_if.send    = 1'b1;
        tick(1);
        u_if.send    = 1'b0;
        chk_all("req_up", 1, 0, 3'b101, 1, 0);
        u_if.data_sw = 3'b010;
        u_if.send    = 1'b1;
        tick(1);
        u_if.send    = 1'b0;
        chk_all("send_ignored", 1, 0, 3'b101, 1, 0);
        u_if.ack = 1'b1;
        tick(2);
        chk_all("ack_lat2", 1, 0, 3'b101, 1, 0);
        tick(1);
        chk_all("ack_lat3", 0, 1, 3'b101, 1, 0);
        u_if.send = 1'b1;
        tick(1);
        u_if.send = 1'b0;
        chk_all("send_in_data", 0, 1, 3'b101, 1, 0);
        u_if.ack = 1'b0;
        tick(2);
        chk_all("rel_lat2", 0, 1, 3'b101, 1, 0);
        tick(1);
        chk_all("rel_lat3", 0, 0, 3'b101, 0, 0);
        tick(3);
        chk_all("no_second_req", 0, 0, 3'b101, 0, 0);

        // no ack: abort after TMO cycles
        u_if.data_sw = 3'b011;
        u_if.send    = 1'b1;
        tick(1);
        u_if.send    = 1'b0;
        chk_all("wa_start", 1, 0, 3'b011, 1, 0);
        tick(TMO - 1);
        chk_all("wa_before_tmo", 1, 0, 3'b011, 1, 0);
        tick(1);
        chk_all("wa_abort", 0, 0, 3'b011, 0, 1);
        tick(2);
        chk_all("wa_err_sticky", 0, 0, 3'b011, 0, 1);

        // next send clears err; ack stuck high aborts SEND_DATA
        u_if.data_sw = 3'b110;
        u_if.send    = 1'b1;
        tick(1);
        u_if.send    = 1'b0;
        chk_all("err_cleared", 1, 0, 3'b110, 1, 0);
        u_if.ack = 1'b1;
        tick(3);
        chk_all("sd_enter", 0, 1, 3'b110, 1, 0);
        tick(TMO - 1);
        chk_all("sd_before_tmo", 0, 1, 3'b110, 1, 0);
        tick(1);
        chk_all("sd_abort", 0, 0, 3'b110, 0, 1);
        u_if.ack = 1'b0;
        tick(4);
        chk_all("sd_idle", 0, 0, 3'b110, 0, 1);

        // reset mid-transfer in SEND_DATA
        u_if.data_sw = 3'b100;
        u_if.send    = 1'b1;
        tick(1);
        u_if.send    = 1'b0;
        u_if.ack     = 1'b1;
        tick(3);
        chk_all("pre_rst", 0, 1, 3'b100, 1, 0);
        rst = 1'b1;
        tick(1);
        chk_all("mid_rst", 0, 0, 3'b000, 0, 0);
        rst      = 1'b0;
        u_if.ack = 1'b0;
        tick(3);

        // transfer after reset completes normally
        u_if.data_sw = 3'b111;
        u_if.send    = 1'b1;
        tick(1);
        u_if.send    = 1'b0;
        chk_all("post_req", 1, 0, 3'b111, 1, 0);
        u_if.ack = 1'b1;
        tick(3);
        chk_all("post_valid", 0, 1, 3'b111, 1, 0);
        u_if.ack = 1'b0;
        tick(3);
        chk_all("post_done", 0, 0, 3'b111, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_master_control
`default_nettype wire
